// File: rtl/array_packed_arbiter.sv
// Arbitrated single-port access to a packed WA x WB word array, with a clear sweep and registered flat export.
// Define ARRAY_PACKED_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed top priority.
module array_packed_arbiter #(
   parameter int WA = 8,
   parameter int WB = 8,
   parameter int NR = 2,
   localparam int AW = $clog2(WA)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NR-1:0]    req_valid,
   output logic [NR-1:0]    req_ready,
   input  logic [NR-1:0]    req_we,
   input  logic [NR*AW-1:0] req_adr,
   input  logic [NR*2-1:0]  req_msk,
   input  logic [NR*WB-1:0] req_wdt,
   output logic [NR-1:0]    rsp_valid,
   output logic [WB-1:0]    rsp_rdt,
   input  logic             clr,
   output logic             busy,
   output logic [WA*WB-1:0] arr
);

   localparam int PW = (NR > 1) ? $clog2(NR) : 1;
   localparam int HW = WB / 2;
   localparam logic [AW:0] WA_L = (AW + 1)'(WA);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                 state;
   logic [WA-1:0][WB-1:0]  mem;
   logic [AW-1:0]          cnt;
   logic [PW-1:0]          gnt_idx;
   logic                   gnt_any;
   logic                   sel_we;
   logic [AW-1:0]          sel_adr;
   logic [1:0]             sel_msk;
   logic [WB-1:0]          sel_wdt;
   logic                   adr_ok;
   logic [WB-1:0]          rd_word;
   logic [WB-1:0]          wr_word;

`ifdef ARRAY_PACKED_ARBITER_RR_EN
   logic [PW-1:0]          ptr;
`endif

   assign arr = mem;

   // Grant search; the loop runs from the lowest-priority slot so the closest match overwrites last.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (state == IDLE && !clr) begin
         for (int k = NR - 1; k >= 0; k--) begin
`ifdef ARRAY_PACKED_ARBITER_RR_EN
            if (req_valid[(int'(ptr) + k) % NR]) begin
               gnt_any = 1'b1;
               gnt_idx = PW'((int'(ptr) + k) % NR);
            end
`else
            if (req_valid[k]) begin
               gnt_any = 1'b1;
               gnt_idx = PW'(k);
            end
`endif
         end
      end
   end

   assign req_ready = gnt_any ? (NR'(1) << gnt_idx) : '0;

   // Route the granted requester's fields onto the single array port.
   always_comb begin
      sel_we  = req_we[gnt_idx];
      sel_adr = req_adr[gnt_idx*AW +: AW];
      sel_msk = req_msk[gnt_idx*2 +: 2];
      sel_wdt = req_wdt[gnt_idx*WB +: WB];
      adr_ok  = ({1'b0, sel_adr} < WA_L);
      rd_word = adr_ok ? mem[sel_adr] : '0;
      wr_word = {sel_msk[1] ? sel_wdt[WB-1:HW] : rd_word[WB-1:HW],
                 sel_msk[0] ? sel_wdt[HW-1:0]  : rd_word[HW-1:0]};
   end

   // Controller: clear always beats a request in IDLE; the sweep zeroes one word per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem       <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         rsp_valid <= '0;
         rsp_rdt   <= '0;
`ifdef ARRAY_PACKED_ARBITER_RR_EN
         ptr       <= '0;
`endif
      end else begin
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end else if (gnt_any) begin
                  if (sel_we) begin
                     if (adr_ok) begin
                        mem[sel_adr] <= wr_word;
                     end
                  end else begin
                     rsp_valid <= req_ready;
                     rsp_rdt   <= rd_word;
                  end
`ifdef ARRAY_PACKED_ARBITER_RR_EN
                  ptr <= (gnt_idx == PW'(NR - 1)) ? '0 : gnt_idx + PW'(1);
`endif
               end
            end
            CLEAR: begin
               mem[cnt] <= '0;
               if (cnt == AW'(WA - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
